// File: rtl/sprite_compositor_pkg.sv
// Shared types and widths for the sprite compositor.
package sprite_compositor_pkg;

    localparam int unsigned VGA_RGB_W   = 12;
    localparam int unsigned X_POS_W     = 10;
    localparam int unsigned Y_POS_W     = 10;
    localparam int unsigned MAX_SPRITES = 16;

    // Sprite box; only pixels strictly inside (x_pos, right) x (y_pos, bottom) are drawn.
    typedef struct packed {
        logic [X_POS_W-1:0] x_pos;
        logic [Y_POS_W-1:0] y_pos;
        logic [X_POS_W-1:0] right;
        logic [Y_POS_W-1:0] bottom;
    } sprite_t;

    // Index wide enough for any sprite slot.
    typedef logic [$clog2(MAX_SPRITES)-1:0] sprite_id_t;

    // Sprite index width for n slots, never below one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Sprite table bus from game logic into the compositor.
interface sprite_compositor_if #(
    parameter int unsigned N_SPRITES = 4
) ();

    sprite_compositor_pkg::sprite_t [N_SPRITES-1:0]                                       sprites;
    logic [N_SPRITES-1:0][sprite_compositor_pkg::VGA_RGB_W-1:0]                            colour;
    logic [N_SPRITES-1:0]                                                                  enable;

    // Game logic drives the table.
    modport master (
        output sprites,
        output colour,
        output enable
    );

    // Compositor samples the table per pixel.
    modport slave (
        input sprites,
        input colour,
        input enable
    );

endinterface

// File: rtl/sprite_compositor_hit_test.sv
// Combinational box test for one sprite; SPRITE_OUTLINE_EN restricts hits to the inner ring.
module sprite_hit_test
    import sprite_compositor_pkg::*;
(
    input  logic [X_POS_W-1:0] pixel_x_i,
    input  logic [Y_POS_W-1:0] pixel_y_i,
    input  logic               pixel_valid_i,
    input  logic               enable_i,
    input  sprite_t            sprite_i,
`ifdef SPRITE_OUTLINE_EN
    input  logic               outline_i,
`endif
    output logic               hit_c_o
);

    logic inside_c;

    // Strict unsigned compares keep the box edges undrawn.
    assign inside_c = enable_i & pixel_valid_i
                    & (pixel_x_i > sprite_i.x_pos) & (pixel_x_i < sprite_i.right)
                    & (pixel_y_i > sprite_i.y_pos) & (pixel_y_i < sprite_i.bottom);

`ifdef SPRITE_OUTLINE_EN
    logic ring_c;

    // Inner ring: first/last drawable column or row; wrap cases are already excluded by inside_c.
    assign ring_c = (pixel_x_i == X_POS_W'(sprite_i.x_pos + X_POS_W'(1)))
                  | (pixel_x_i == X_POS_W'(sprite_i.right - X_POS_W'(1)))
                  | (pixel_y_i == Y_POS_W'(sprite_i.y_pos + Y_POS_W'(1)))
                  | (pixel_y_i == Y_POS_W'(sprite_i.bottom - Y_POS_W'(1)));

    assign hit_c_o = inside_c & (~outline_i | ring_c);
`else
    assign hit_c_o = inside_c;
`endif

endmodule

// File: rtl/sprite_compositor.sv
// N-sprite compositor: two-stage pixel pipeline plus per-frame collision flags.
// Optional macro SPRITE_OUTLINE_EN adds outline_i (ring-only sprites).
module sprite_compositor
    import sprite_compositor_pkg::*;
#(
    parameter  int unsigned N_SPRITES = 4,
    localparam int unsigned ID_W      = id_width(N_SPRITES)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [X_POS_W-1:0]   pixel_x_i,
    input  logic [Y_POS_W-1:0]   pixel_y_i,
    input  logic                 pixel_valid_i,
    input  logic                 frame_start_i,
    sprite_compositor_if.slave   cfg_if,
`ifdef SPRITE_OUTLINE_EN
    input  logic [N_SPRITES-1:0] outline_i,
`endif
    output logic [VGA_RGB_W-1:0] vga_rgb_o,
    output logic                 on_sprite_o,
    output logic [ID_W-1:0]      sprite_id_o,
    output logic [N_SPRITES-1:0] collision_o,
    output logic                 collision_valid_o
);

    logic [N_SPRITES-1:0]                hit_c;
    logic [N_SPRITES-1:0]                hit_q;
    logic [N_SPRITES-1:0][VGA_RGB_W-1:0] colour_q;
    logic [N_SPRITES-1:0]                overlap_c;
    logic [N_SPRITES-1:0]                acc_q,  acc_d;
    logic [N_SPRITES-1:0]                coll_q, coll_d;
    logic                                coll_vld_q, coll_vld_d;
    logic [VGA_RGB_W-1:0]                rgb_q,  rgb_d;
    logic                                on_q,   on_d;
    logic [ID_W-1:0]                     id_q,   id_d;

    // One box tester per sprite slot.
    for (genvar g = 0; g < N_SPRITES; g++) begin : g_hit
        sprite_hit_test u_hit (
`ifdef SPRITE_OUTLINE_EN
            .outline_i     (outline_i[g]),
`endif
            .pixel_x_i     (pixel_x_i),
            .pixel_y_i     (pixel_y_i),
            .pixel_valid_i (pixel_valid_i),
            .enable_i      (cfg_if.enable[g]),
            .sprite_i      (cfg_if.sprites[g]),
            .hit_c_o       (hit_c[g])
        );
    end

    // Stage 1: capture the hit vector together with the colours of this pixel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_q    <= '0;
            colour_q <= '0;
        end else begin
            hit_q    <= hit_c;
            colour_q <= cfg_if.colour;
        end
    end

    // Stage 2 select: lowest set index wins.
    always_comb begin
        rgb_d = '0;
        on_d  = 1'b0;
        id_d  = '0;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (hit_q[i]) begin
                rgb_d = colour_q[i];
                on_d  = 1'b1;
                id_d  = ID_W'(i);
            end
        end
    end

    // A sprite collides when it and at least one other sprite are drawn on the same pixel.
    always_comb begin
        overlap_c = '0;
        for (int i = 0; i < N_SPRITES; i++) begin
            overlap_c[i] = hit_q[i] & (|(hit_q & ~(N_SPRITES'(1) << i)));
        end
    end

    // Frame boundary publishes the old frame (including the pixel still in stage 1) and clears.
    always_comb begin
        acc_d      = acc_q | overlap_c;
        coll_d     = coll_q;
        coll_vld_d = 1'b0;
        if (frame_start_i) begin
            acc_d      = '0;
            coll_d     = acc_q | overlap_c;
            coll_vld_d = 1'b1;
        end
    end

    // Output and collision registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rgb_q      <= '0;
            on_q       <= 1'b0;
            id_q       <= '0;
            acc_q      <= '0;
            coll_q     <= '0;
            coll_vld_q <= 1'b0;
        end else begin
            rgb_q      <= rgb_d;
            on_q       <= on_d;
            id_q       <= id_d;
            acc_q      <= acc_d;
            coll_q     <= coll_d;
            coll_vld_q <= coll_vld_d;
        end
    end

    assign vga_rgb_o         = rgb_q;
    assign on_sprite_o       = on_q;
    assign sprite_id_o       = id_q;
    assign collision_o       = coll_q;
    assign collision_valid_o = coll_vld_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor against a per-pixel behavioural model.
module tb_sprite_compositor;
    import sprite_compositor_pkg::*;

    localparam int unsigned N = 4;

    typedef struct {
        int         x, y, r, b;
        logic [11:0] c;
        logic       e;
        logic       o;
    } box_t;

    typedef struct packed {
        logic [11:0] rgb;
        logic        on;
        logic [1:0]  id;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [9:0]    px, py;
    logic          pv, fs;
    logic [N-1:0]  outline;
    logic [11:0]   vga_rgb;
    logic          on_sprite;
    logic [1:0]    sprite_id;
    logic [N-1:0]  collision;
    logic          coll_valid;

    box_t stg[N];
    box_t cur[N];
    int   checks = 0;
    int   errors = 0;

    sprite_compositor_if #(.N_SPRITES(N)) cfg_if ();

    sprite_compositor #(.N_SPRITES(N)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .pixel_x_i         (px),
        .pixel_y_i         (py),
        .pixel_valid_i     (pv),
        .frame_start_i     (fs),
        .cfg_if            (cfg_if.slave),
`ifdef SPRITE_OUTLINE_EN
        .outline_i         (outline),
`endif
        .vga_rgb_o         (vga_rgb),
        .on_sprite_o       (on_sprite),
        .sprite_id_o       (sprite_id),
        .collision_o       (collision),
        .collision_valid_o (coll_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Spec-level pixel test for sprite i.
    function automatic logic m_hit(input int i, input int x, input int y, input logic v);
        logic h;
        h = cur[i].e && v && (x > cur[i].x) && (x < cur[i].r) && (y > cur[i].y) && (y < cur[i].b);
`ifdef SPRITE_OUTLINE_EN
        if (cur[i].o)
            h = h && (x == cur[i].x + 1 || x == cur[i].r - 1 || y == cur[i].y + 1 || y == cur[i].b - 1);
`endif
        return h;
    endfunction

    // Compare process: model the pipeline at the frame/pixel level and check every cycle.
    initial begin
        exp_t         s1, s2, e;
        logic [N-1:0] facc, ecoll, h, ov;
        logic         evalid;
        s1 = '0; s2 = '0; facc = '0; ecoll = '0; evalid = 1'b0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                s1 = '0; s2 = '0; facc = '0; ecoll = '0; evalid = 1'b0;
            end else begin
                s2 = s1;
                for (int i = 0; i < N; i++) h[i] = m_hit(i, int'(px), int'(py), pv);
                e = '0;
                for (int i = N - 1; i >= 0; i--)
                    if (h[i]) begin e.rgb = cur[i].c; e.on = 1'b1; e.id = 2'(i); end
                s1 = e;
                ov = ($countones(h) > 1) ? h : '0;
                if (fs) begin
                    ecoll  = facc | '0;
                    evalid = 1'b1;
                    facc   = ov;
                end else begin
                    evalid = 1'b0;
                    facc   = facc | ov;
                end
            end
            #1;
            chk("rgb", 32'(vga_rgb), 32'(s2.rgb));
            chk("on_sprite", 32'(on_sprite), 32'(s2.on));
            chk("sprite_id", 32'(sprite_id), 32'(s2.id));
            chk("collision", 32'(collision), 32'(ecoll));
            chk("coll_valid", 32'(coll_valid), 32'(evalid));
        end
    end

    // Apply one pixel and the staged sprite table at the next falling edge.
    task automatic drive(input int x, input int y, input logic v, input logic f);
        @(negedge clk);
        px = 10'(x); py = 10'(y); pv = v; fs = f;
        for (int i = 0; i < N; i++) begin
            cur[i] = stg[i];
            cfg_if.sprites[i].x_pos  = 10'(stg[i].x);
            cfg_if.sprites[i].y_pos  = 10'(stg[i].y);
            cfg_if.sprites[i].right  = 10'(stg[i].r);
            cfg_if.sprites[i].bottom = 10'(stg[i].b);
            cfg_if.colour[i]         = stg[i].c;
            cfg_if.enable[i]         = stg[i].e;
            outline[i]               = stg[i].o;
        end
    endtask

    task automatic idle();
        drive(0, 0, 1'b0, 1'b0);
    endtask

    task automatic set_box(input int i, input int x, input int y, input int r, input int b,
                           input logic [11:0] c, input logic e);
        stg[i].x = x; stg[i].y = y; stg[i].r = r; stg[i].b = b;
        stg[i].c = c; stg[i].e = e; stg[i].o = 1'b0;
    endtask

    // Single pixel, then literal check of its output two edges later.
    task automatic probe(input string nm, input int x, input int y,
                         input logic eon, input logic [11:0] ergb, input logic [1:0] eid);
        drive(x, y, 1'b1, 1'b0);
        idle();
        @(posedge clk); #2;
        chk({nm, "_on"}, 32'(on_sprite), 32'(eon));
        chk({nm, "_rgb"}, 32'(vga_rgb), 32'(ergb));
        chk({nm, "_id"}, 32'(sprite_id), 32'(eid));
    endtask

    // Frame-start pulse with literal check of the published flags.
    task automatic frame_pub(input string nm, input logic [N-1:0] req);
        drive(0, 0, 1'b0, 1'b1);
        @(posedge clk); #2;
        chk({nm, "_coll"}, 32'(collision), 32'(req));
        chk({nm, "_vld"}, 32'(coll_valid), 32'd1);
    endtask

    task automatic async_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("rst_rgb", 32'(vga_rgb), 32'd0);
        chk("rst_on", 32'(on_sprite), 32'd0);
        chk("rst_id", 32'(sprite_id), 32'd0);
        chk("rst_coll", 32'(collision), 32'd0);
        chk("rst_vld", 32'(coll_valid), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        px = '0; py = '0; pv = 1'b0; fs = 1'b0; outline = '0;
        cfg_if.sprites = '0; cfg_if.colour = '0; cfg_if.enable = '0;
        for (int i = 0; i < N; i++) begin set_box(i, 0, 0, 0, 0, 12'h000, 1'b0); cur[i] = stg[i]; end
        #2;
        chk("por_on", 32'(on_sprite), 32'd0);
        chk("por_coll", 32'(collision), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Priority overlap
        set_box(0, 10, 10, 20, 20, 12'hF00, 1'b1);
        set_box(1, 18, 18, 30, 30, 12'h0F0, 1'b0);
        set_box(2, 15, 15, 30, 30, 12'h00F, 1'b1);
        probe("prio_a", 16, 16, 1'b1, 12'hF00, 2'd0);
        probe("prio_b", 25, 25, 1'b1, 12'h00F, 2'd2);

        // Edge exclusivity
        stg[2].e = 1'b0;
        probe("edge_l", 10, 15, 1'b0, 12'h000, 2'd0);
        probe("edge_r", 20, 15, 1'b0, 12'h000, 2'd0);
        probe("edge_in", 11, 15, 1'b1, 12'hF00, 2'd0);

        // Frame so far had s0/s2 overlap at (16,16)
        frame_pub("first_frame", 4'b0101);

        // Collision latch, then a clean frame
        stg[1].e = 1'b1;
        drive(19, 19, 1'b1, 1'b0);
        idle();
        frame_pub("latch", 4'b0011);
        drive(25, 25, 1'b1, 1'b0);
        idle();
        frame_pub("clean", 4'b0000);

        // Overlap on the last pixel before the boundary, then back-to-back pulse
        drive(12, 12, 1'b1, 1'b0);
        drive(19, 19, 1'b1, 1'b0);
        frame_pub("boundary", 4'b0011);
        frame_pub("b2b", 4'b0000);

        // Enable and valid gating
        stg[0].e = 1'b0;
        probe("en_gate", 15, 15, 1'b0, 12'h000, 2'd0);
        stg[0].e = 1'b1;
        drive(19, 19, 1'b0, 1'b0);
        idle();
        @(posedge clk); #2;
        chk("valid_gate_on", 32'(on_sprite), 32'd0);
        frame_pub("valid_gate", 4'b0000);

        // Reset mid-frame discards the accumulated overlap
        drive(19, 19, 1'b1, 1'b0);
        frame_pub("pre_rst", 4'b0011);
        drive(19, 19, 1'b1, 1'b0);
        idle();
        async_reset();
        drive(25, 25, 1'b1, 1'b0);
        idle();
        frame_pub("post_rst", 4'b0000);

`ifdef SPRITE_OUTLINE_EN
        stg[1].e = 1'b0;
        stg[0].o = 1'b1;
        probe("ring_hit", 11, 15, 1'b1, 12'hF00, 2'd0);
        probe("ring_miss", 15, 15, 1'b0, 12'h000, 2'd0);
        stg[0].o = 1'b0;
`endif

        // Randomised traffic checked by the compare process
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                for (int i = 0; i < N; i++) begin
                    int x0, y0;
                    x0 = int'($urandom_range(0, 40));
                    y0 = int'($urandom_range(0, 40));
                    set_box(i, x0, y0, x0 + int'($urandom_range(0, 24)), y0 + int'($urandom_range(0, 24)),
                            12'($urandom), 1'($urandom_range(0, 3) != 0));
`ifdef SPRITE_OUTLINE_EN
                    stg[i].o = 1'($urandom_range(0, 2) == 0);
`endif
                end
            end
            if (c == 1500) async_reset();
            drive(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                  1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 49) == 0));
        end
        idle();
        repeat (3) idle();
        @(posedge clk); #3;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
